// File: rtl/coherent_dcache_ctrl_if.sv
// Bus-side signal bundle between one coherent_dcache_ctrl and the snooping bus arbiter.
//   master : the cache controller. It drives the miss/upgrade requests, the BICO request
//            address and the snoop responses. It receives grant, the snoop command, the
//            snoop address and the remote invalidate.
//   slave  : the bus arbiter, with the opposite directions.
interface coherent_dcache_ctrl_if;
   logic        read_miss;
   logic        write_miss;
   logic        invalidate;
   logic [12:0] BICO;
   logic        grant;
   logic        snoop_search;
   logic [12:0] snoop_addr;
   logic        search_found;
   logic [1:0]  block_state;
   logic        inv_from_other;

   modport master (
      output read_miss, write_miss, invalidate, BICO, search_found, block_state,
      input  grant, snoop_search, snoop_addr, inv_from_other
   );

   modport slave (
      input  read_miss, write_miss, invalidate, BICO, search_found, block_state,
      output grant, snoop_search, snoop_addr, inv_from_other
   );
endinterface

// File: rtl/coherent_dcache_ctrl.sv
// Per-CPU MSI coherence controller for a direct-mapped data cache.
// The controller owns the tag/state array and resolves CPU hits and misses in the same
// cycle as the request. It raises read-miss, write-miss or S->M upgrade requests on the
// bus, holds them until grant, installs the line after FILL_LAT cycles and answers the
// bus's snoop-search and remote-invalidate commands.
// Ports:
//   clk, rst_n                : clock and asynchronous active-low reset
//   cpu_re/cpu_we/cpu_addr    : CPU load/store request; a store has priority over a load
//   stall, hit                : CPU handshake
//   data_we, fill_we, line_idx: data-array write strobes and their index
//   evict_dirty, evict_addr   : pulse and block address when a modified line is replaced
//   bus                       : bus-side interface (master modport)
module coherent_dcache_ctrl #(
   parameter int unsigned IDX_W    = 4,
   parameter int unsigned OFF_W    = 2,
   parameter int unsigned FILL_LAT = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_re,
   input  logic                  cpu_we,
   input  logic [12:0]           cpu_addr,
   output logic                  stall,
   output logic                  hit,
   output logic                  data_we,
   output logic                  fill_we,
   output logic [IDX_W-1:0]      line_idx,
   output logic                  evict_dirty,
   output logic [12:0]           evict_addr,
   coherent_dcache_ctrl_if.master bus
);

   localparam int unsigned TAG_W = 13 - IDX_W - OFF_W;
   localparam int unsigned LINES = 1 << IDX_W;
   localparam int unsigned CNT_W = (FILL_LAT > 1) ? $clog2(FILL_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILL_LAT - 1);

   localparam logic [1:0] LS_I = 2'b00;
   localparam logic [1:0] LS_S = 2'b01;
   localparam logic [1:0] LS_M = 2'b10;

   typedef enum logic [2:0] {StIdle, StReqRd, StReqWr, StReqInv, StFill} state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [12:0]      addr_q;
   logic             wr_q;
   logic [1:0]       st_q  [LINES];
   logic [TAG_W-1:0] tag_q [LINES];

   logic [IDX_W-1:0] cpu_idx, s_idx, lat_idx;
   logic [TAG_W-1:0] cpu_tag, s_tag, lat_tag;
   logic             cpu_hit, cpu_is_m, s_hit, inv_match, fill_last;

   assign cpu_idx = cpu_addr[OFF_W +: IDX_W];
   assign cpu_tag = cpu_addr[12 -: TAG_W];
   assign s_idx   = bus.snoop_addr[OFF_W +: IDX_W];
   assign s_tag   = bus.snoop_addr[12 -: TAG_W];
   assign lat_idx = addr_q[OFF_W +: IDX_W];
   assign lat_tag = addr_q[12 -: TAG_W];

   assign cpu_hit  = (st_q[cpu_idx] != LS_I) && (tag_q[cpu_idx] == cpu_tag);
   assign cpu_is_m = (st_q[cpu_idx] == LS_M);
   assign s_hit    = (st_q[s_idx] != LS_I) && (tag_q[s_idx] == s_tag);
   // A remote invalidate hitting the line we hold in S kills the pending upgrade.
   assign inv_match = bus.inv_from_other && s_hit && (s_idx == lat_idx);
   assign fill_last = (state_q == StFill) && (cnt_q == CNT_LAST);

   // Offset bits never take part in tag/state lookups.
   logic unused_offset;
   assign unused_offset = ^{cpu_addr[OFF_W-1:0], bus.snoop_addr[OFF_W-1:0]};

   // Snoop responses are combinational from the pre-edge array.
   assign bus.search_found = bus.snoop_search && s_hit;
   assign bus.block_state  = s_hit ? st_q[s_idx] : LS_I;
   assign bus.BICO         = addr_q;
   assign bus.read_miss    = (state_q == StReqRd);
   assign bus.write_miss   = (state_q == StReqWr);
   assign bus.invalidate   = (state_q == StReqInv);

   always_comb begin
      stall       = 1'b0;
      hit         = 1'b0;
      data_we     = 1'b0;
      fill_we     = 1'b0;
      line_idx    = cpu_idx;
      evict_dirty = 1'b0;
      evict_addr  = 13'h0;
      unique case (state_q)
         StIdle: begin
            if (cpu_we) begin
               if (cpu_hit && cpu_is_m) begin
                  hit     = 1'b1;
                  data_we = 1'b1;
               end else begin
                  stall = 1'b1;
               end
            end else if (cpu_re) begin
               if (cpu_hit) hit = 1'b1;
               else         stall = 1'b1;
            end
         end
         StReqRd, StReqWr, StReqInv: stall = 1'b1;
         StFill: begin
            stall = 1'b1;
            if (fill_last) begin
               fill_we  = 1'b1;
               line_idx = lat_idx;
               if ((st_q[lat_idx] == LS_M) && (tag_q[lat_idx] != lat_tag)) begin
                  evict_dirty = 1'b1;
                  evict_addr  = {tag_q[lat_idx], lat_idx, {OFF_W{1'b0}}};
               end
            end
         end
         default: stall = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         addr_q  <= 13'h0;
         wr_q    <= 1'b0;
         for (int i = 0; i < LINES; i++) begin
            st_q[i]  <= LS_I;
            tag_q[i] <= '0;
         end
      end else begin
         // Remote invalidate first; FSM writes below take precedence only where they
         // cannot conflict (the line being filled ignores remote invalidates).
         if (bus.inv_from_other && s_hit && !((state_q == StFill) && (s_idx == lat_idx))) begin
            st_q[s_idx] <= LS_I;
         end
         unique case (state_q)
            StIdle: begin
               if (cpu_we && !(cpu_hit && cpu_is_m)) begin
                  addr_q  <= cpu_addr;
                  wr_q    <= 1'b1;
                  state_q <= cpu_hit ? StReqInv : StReqWr;
               end else if (!cpu_we && cpu_re && !cpu_hit) begin
                  addr_q  <= cpu_addr;
                  wr_q    <= 1'b0;
                  state_q <= StReqRd;
               end
            end
            StReqRd, StReqWr: begin
               if (bus.grant) begin
                  cnt_q   <= '0;
                  state_q <= StFill;
               end
            end
            StReqInv: begin
               if (inv_match) begin
                  state_q <= StReqWr;
               end else if (bus.grant) begin
                  st_q[lat_idx] <= LS_M;
                  state_q       <= StIdle;
               end
            end
            StFill: begin
               if (cnt_q == CNT_LAST) begin
                  tag_q[lat_idx] <= lat_tag;
                  st_q[lat_idx]  <= wr_q ? LS_M : LS_S;
                  cnt_q          <= '0;
                  state_q        <= StIdle;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
